vliw_sequencer: RTL and testbench

VLIW_SEQUENCER -- requirements
Module: vliw_sequencer

---
 rtl/vliw_sequencer_pkg.sv | 28 ++
 rtl/vliw_sequencer_insdecoder.sv | 21 ++
 rtl/vliw_sequencer.sv | 140 ++++++++++++++
 tb/tb_vliw_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vliw_sequencer_pkg.sv
// rtl/vliw_sequencer_pkg.sv - shared constants, bundle bit positions and FSM state type
package vliw_sequencer_pkg;

   localparam int NSLOTS = 41;
   localparam int PC_W   = 16;
   localparam int SLOT_W = 24;
   localparam int INS_W  = 1024;

   localparam logic [15:0] HALT_ADDR = 16'hFFFF;

   // Bundle layout, MSB first: meta | eval_len | operand | 41 slots | next
   localparam int META_BIT    = 1023;
   localparam int EVAL_LEN_HI = 1022;
   localparam int EVAL_LEN_LO = 1016;
   localparam int OPERAND_HI  = 1015;
   localparam int OPERAND_LO  = 1000;
   localparam int SLOT0_HI    = 999;
   localparam int NEXT_HI     = 15;
   localparam int NEXT_LO     = 0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_HALT
   } state_t;

endpackage

// File: rtl/vliw_sequencer_insdecoder.sv
// rtl/vliw_sequencer_insdecoder.sv - header field extraction from a latched bundle
module vliw_sequencer_insdecoder
   import vliw_sequencer_pkg::*;
(
   input  logic [INS_W-1:0] ins,
   output logic             meta,
   output logic [6:0]       eval_len,
   output logic [15:0]      operand,
   output logic [15:0]      next
);

   assign meta     = ins[META_BIT];
   assign eval_len = ins[EVAL_LEN_HI:EVAL_LEN_LO];
   assign operand  = ins[OPERAND_HI:OPERAND_LO];
   assign next     = ins[NEXT_HI:NEXT_LO];

   // Slot bits are selected by the sequencer's own mux, not here
   logic unused_slots;
   assign unused_slots = ^ins[SLOT0_HI:NEXT_HI+1];

endmodule

// File: rtl/vliw_sequencer.sv
// rtl/vliw_sequencer.sv - fetches 1024-bit VLIW bundles and issues their ALU slots one per handshake
module vliw_sequencer #(
   parameter int NSLOTS = vliw_sequencer_pkg::NSLOTS,
   parameter int PC_W   = vliw_sequencer_pkg::PC_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [PC_W-1:0] start_pc,
   output logic            fetch_req,
   output logic [PC_W-1:0] fetch_addr,
   input  logic            fetch_valid,
   input  logic [1023:0]   fetch_ins,
   output logic            alu_valid,
   input  logic            alu_ready,
   output logic [7:0]      alu_code,
   output logic [7:0]      alu_src,
   output logic [7:0]      alu_dst,
   output logic            busy,
   output logic            halted
);
   import vliw_sequencer_pkg::*;

   localparam int IDX_W = $clog2(NSLOTS);

   state_t            state, state_nxt;
   logic [PC_W-1:0]   pc, pc_nxt;
   logic [IDX_W-1:0]  idx, idx_nxt, last_idx;
   logic              halted_nxt;
   logic              load;
   logic [INS_W-1:0]  bundle;
   logic [SLOT_W-1:0] slot;

   logic              hdr_meta;
   logic [6:0]        hdr_eval_len;
   logic [15:0]       hdr_operand;
   logic [15:0]       hdr_next;
   logic              unused_hdr;

   // The transfer decision must be made on the incoming bundle, before it is latched
   logic              in_meta;
   logic [6:0]        in_eval_len;
   logic [15:0]       in_operand;
   logic [15:0]       in_next;

   assign in_meta     = fetch_ins[META_BIT];
   assign in_eval_len = fetch_ins[EVAL_LEN_HI:EVAL_LEN_LO];
   assign in_operand  = fetch_ins[OPERAND_HI:OPERAND_LO];
   assign in_next     = fetch_ins[NEXT_HI:NEXT_LO];

   vliw_sequencer_insdecoder u_insdecoder (
      .ins      (bundle),
      .meta     (hdr_meta),
      .eval_len (hdr_eval_len),
      .operand  (hdr_operand),
      .next     (hdr_next)
   );

   assign unused_hdr = ^{hdr_meta, hdr_operand};

   // Issue count is min(eval_len, NSLOTS); excess slots are dropped silently
   assign last_idx = (hdr_eval_len > 7'(NSLOTS)) ? IDX_W'(NSLOTS - 1)
                                                  : IDX_W'(hdr_eval_len - 7'd1);

   always_comb begin
      slot = '0;
      for (int k = 0; k < NSLOTS; k++) begin
         if (idx == IDX_W'(k)) slot = bundle[SLOT0_HI - SLOT_W*k -: SLOT_W];
      end
   end

   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc;
      idx_nxt    = idx;
      halted_nxt = halted;
      load       = 1'b0;
      unique case (state)
         S_IDLE, S_HALT: begin
            if (start) begin
               state_nxt  = S_FETCH;
               pc_nxt     = start_pc;
               halted_nxt = 1'b0;
            end
         end
         S_FETCH: begin
            if (fetch_valid) begin
               load = 1'b1;
               if (in_meta && in_operand == HALT_ADDR) begin
                  state_nxt  = S_HALT;
                  halted_nxt = 1'b1;
               end else if (in_meta) begin
                  pc_nxt = PC_W'(in_operand);
               end else if (in_eval_len == 7'd0) begin
                  pc_nxt = PC_W'(in_next);
               end else begin
                  state_nxt = S_ISSUE;
                  idx_nxt   = '0;
               end
            end
         end
         S_ISSUE: begin
            if (alu_ready) begin
               if (idx == last_idx) begin
                  state_nxt = S_FETCH;
                  pc_nxt    = PC_W'(hdr_next);
               end else begin
                  idx_nxt = idx + 1'b1;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         pc     <= '0;
         idx    <= '0;
         halted <= 1'b0;
         bundle <= '0;
      end else begin
         state  <= state_nxt;
         pc     <= pc_nxt;
         idx    <= idx_nxt;
         halted <= halted_nxt;
         if (load) bundle <= fetch_ins;
      end
   end

   assign fetch_req  = (state == S_FETCH);
   assign fetch_addr = pc;
   assign alu_valid  = (state == S_ISSUE);
   assign busy       = fetch_req | alu_valid;
   assign alu_code   = slot[23:16];
   assign alu_src    = slot[15:8];
   assign alu_dst    = slot[7:0];

endmodule

// File: tb/tb_vliw_sequencer.sv
// tb/tb_vliw_sequencer.sv - directed and randomized self-checking bench for vliw_sequencer
module tb_vliw_sequencer;

   localparam int NS = 41;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [15:0]   start_pc;
   logic          fetch_req;
   logic [15:0]   fetch_addr;
   logic          fetch_valid;
   logic [1023:0] fetch_ins;
   logic          alu_valid;
   logic          alu_ready;
   logic [7:0]    alu_code;
   logic [7:0]    alu_src;
   logic [7:0]    alu_dst;
   logic          busy;
   logic          halted;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   logic [23:0] slot_tbl [NS];

   vliw_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .start_pc    (start_pc),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_valid (fetch_valid),
      .fetch_ins   (fetch_ins),
      .alu_valid   (alu_valid),
      .alu_ready   (alu_ready),
      .alu_code    (alu_code),
      .alu_src     (alu_src),
      .alu_dst     (alu_dst),
      .busy        (busy),
      .halted      (halted)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (failure #%0d)", tag, obs, exp, n_fail);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic new_slots();
      for (int k = 0; k < NS; k++) slot_tbl[k] = 24'($urandom);
   endtask

   function automatic logic [1023:0] build(input logic meta, input logic [6:0] elen,
                                           input logic [15:0] opnd, input logic [15:0] nxt);
      logic [1023:0] b;
      b = '0;
      b[1023]      = meta;
      b[1022:1016] = elen;
      b[1015:1000] = opnd;
      for (int k = 0; k < NS; k++) b[999 - 24*k -: 24] = slot_tbl[k];
      b[15:0]      = nxt;
      return b;
   endfunction

   // Waits for a fetch request, holds off a random number of cycles, then transfers b
   task automatic deliver(input logic [1023:0] b, input logic [15:0] exp_addr);
      int cyc;
      int d;
      cyc = 0;
      while (fetch_req !== 1'b1 && cyc < 20) begin
         tick();
         cyc++;
      end
      check("fetch_req_seen", {31'd0, fetch_req}, 32'd1);
      d = $urandom_range(2);
      repeat (d) begin
         check("fetch_addr_hold", {16'd0, fetch_addr}, {16'd0, exp_addr});
         tick();
      end
      check("fetch_addr", {16'd0, fetch_addr}, {16'd0, exp_addr});
      fetch_ins   = b;
      fetch_valid = 1'b1;
      tick();
      fetch_valid = 1'b0;
      fetch_ins   = {32{$urandom}};
   endtask

   // Expected issue stream is slot_tbl[0 .. n_exp-1] in order, then a fetch of exp_next
   task automatic run_issue(input int n_exp, input int stall_pct, input int force_slot,
                            input int force_len, input logic [15:0] exp_next);
      int          n_obs;
      int          cyc;
      int          forced;
      logic        stalled;
      logic        rdy;
      logic [23:0] held;
      n_obs   = 0;
      cyc     = 0;
      forced  = 0;
      stalled = 1'b0;
      held    = '0;
      check("issue_latency", {31'd0, alu_valid}, 32'd1);
      while (alu_valid === 1'b1 && cyc < 500) begin
         if (stalled) check("stall_hold", {8'd0, alu_code, alu_src, alu_dst}, {8'd0, held});
         if (n_obs == force_slot && forced < force_len) begin
            rdy = 1'b0;
            forced++;
         end else begin
            rdy = ($urandom_range(99) >= stall_pct);
         end
         alu_ready = rdy;
         if (rdy) begin
            if (n_obs < NS)
               check("slot_fields", {8'd0, alu_code, alu_src, alu_dst}, {8'd0, slot_tbl[n_obs]});
            n_obs++;
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
            held    = {alu_code, alu_src, alu_dst};
         end
         tick();
         cyc++;
      end
      alu_ready = 1'($urandom_range(1));
      check("issue_count", n_obs, n_exp);
      check("post_fetch_req", {31'd0, fetch_req}, 32'd1);
      check("post_fetch_addr", {16'd0, fetch_addr}, {16'd0, exp_next});
   endtask

   initial begin
      logic [15:0] cur;
      logic [15:0] op;
      logic [15:0] nxt;
      logic [6:0]  elen;
      int          kind;

      rst_n       = 1'b0;
      start       = 1'b0;
      start_pc    = '0;
      fetch_valid = 1'b0;
      fetch_ins   = '0;
      alu_ready   = 1'b0;
      @(negedge clk);
      tick();
      tick();
      check("rst_fetch_req", {31'd0, fetch_req}, 32'd0);
      check("rst_alu_valid", {31'd0, alu_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);
      check("rst_fetch_addr", {16'd0, fetch_addr}, 32'd0);
      check("rst_fields", {8'd0, alu_code, alu_src, alu_dst}, 32'd0);

      // Basic three-slot bundle with the ALU always ready
      rst_n    = 1'b1;
      start    = 1'b1;
      start_pc = 16'h0010;
      tick();
      start = 1'b0;
      check("start_busy", {31'd0, busy}, 32'd1);
      new_slots();
      deliver(build(1'b0, 7'd3, 16'h1234, 16'h0020), 16'h0010);
      run_issue(3, 0, -1, 0, 16'h0020);

      // Slot B back-pressured for four cycles
      new_slots();
      deliver(build(1'b0, 7'd3, 16'h0000, 16'h0030), 16'h0020);
      run_issue(3, 0, 1, 4, 16'h0030);

      // Meta jump, then an empty bundle
      deliver(build(1'b1, 7'd5, 16'h0100, 16'h0040), 16'h0030);
      check("jump_no_issue", {31'd0, alu_valid}, 32'd0);
      new_slots();
      deliver(build(1'b0, 7'd0, 16'h0055, 16'h0031), 16'h0100);
      check("empty_no_issue", {31'd0, alu_valid}, 32'd0);

      // Oversized eval_len clamps to all slots; next of FFFF is an ordinary address
      new_slots();
      deliver(build(1'b0, 7'd100, 16'h0000, 16'hFFFF), 16'h0031);
      run_issue(NS, 30, -1, 0, 16'hFFFF);
      check("wrap_not_halted", {31'd0, halted}, 32'd0);

      // Halt, stray fetch_valid, restart
      deliver(build(1'b1, 7'd0, 16'hFFFF, 16'h1234), 16'hFFFF);
      check("halt_halted", {31'd0, halted}, 32'd1);
      check("halt_busy", {31'd0, busy}, 32'd0);
      check("halt_fetch_req", {31'd0, fetch_req}, 32'd0);
      check("halt_alu_valid", {31'd0, alu_valid}, 32'd0);
      fetch_valid = 1'b1;
      tick();
      fetch_valid = 1'b0;
      check("halt_ignores_fetch", {31'd0, halted}, 32'd1);
      cur      = 16'($urandom);
      start    = 1'b1;
      start_pc = cur;
      tick();
      check("restart_halted", {31'd0, halted}, 32'd0);
      check("restart_addr", {16'd0, fetch_addr}, {16'd0, cur});
      start_pc = cur ^ 16'h5A5A;
      tick();
      start = 1'b0;
      check("start_while_busy", {16'd0, fetch_addr}, {16'd0, cur});

      // Random mix of issue, jump and empty bundles
      for (int it = 0; it < 8; it++) begin
         kind = $urandom_range(2);
         new_slots();
         nxt  = 16'($urandom);
         op   = 16'($urandom);
         elen = 7'($urandom_range(127, 1));
         if (kind == 0) begin
            deliver(build(1'b0, elen, op, nxt), cur);
            run_issue((elen > 7'(NS)) ? NS : int'(elen), 25, -1, 0, nxt);
            cur = nxt;
         end else if (kind == 1) begin
            if (op == 16'hFFFF) op = 16'h0000;
            deliver(build(1'b1, elen, op, nxt), cur);
            check("rand_jump_no_issue", {31'd0, alu_valid}, 32'd0);
            cur = op;
         end else begin
            deliver(build(1'b0, 7'd0, op, nxt), cur);
            check("rand_empty_no_issue", {31'd0, alu_valid}, 32'd0);
            cur = nxt;
         end
      end

      // Reset while slot 2 of 5 is presented
      new_slots();
      deliver(build(1'b0, 7'd5, 16'h0000, 16'h0777), cur);
      alu_ready = 1'b1;
      tick();
      tick();
      check("pre_reset_slot2", {8'd0, alu_code, alu_src, alu_dst}, {8'd0, slot_tbl[2]});
      rst_n = 1'b0;
      tick();
      check("mid_rst_alu_valid", {31'd0, alu_valid}, 32'd0);
      check("mid_rst_fetch_req", {31'd0, fetch_req}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      rst_n       = 1'b1;
      fetch_valid = 1'b1;
      fetch_ins   = build(1'b0, 7'd3, 16'h0000, 16'h0042);
      repeat (3) begin
         tick();
         check("idle_fetch_req", {31'd0, fetch_req}, 32'd0);
         check("idle_alu_valid", {31'd0, alu_valid}, 32'd0);
         check("idle_busy", {31'd0, busy}, 32'd0);
      end
      fetch_valid = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
